// File: rtl/calc_seq_ctrl_pkg.sv
// calc_pkg: FSM states, ALU ops and key codes shared by calc_seq_ctrl (CALC_MUL_EN adds the multiply key)
package calc_pkg;

   // WAIT_EQ reuses the GET_A encoding: operand A is taken directly from IDLE
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_EQ = 3'd1,
      GET_OP  = 3'd2,
      GET_B   = 3'd3,
      EXEC    = 3'd4,
      SHOW_LO = 3'd5,
      SHOW_HI = 3'd6
   } state_t;

   typedef enum logic [1:0] {ADD, SUB, MUL} op_t;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if: keypad strobe in, decoder/latch drive and status out
interface calc_seq_ctrl_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] dec_in;
   logic       out_en;
   logic       nib_sel;
   logic       neg;
   logic       err;
   logic [2:0] state_o;

   modport master (output key_valid, key_code,
                   input  key_ready, dec_in, out_en, nib_sel, neg, err, state_o);
   modport slave  (input  key_valid, key_code,
                   output key_ready, dec_in, out_en, nib_sel, neg, err, state_o);
endinterface

// File: rtl/calc_seq_ctrl_alu.sv
// calc_alu: combinational add / sign-magnitude subtract / optional multiply (CALC_MUL_EN)
module calc_alu
   import calc_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   input  op_t              op,
   output logic [2*OPW-1:0] result,
   output logic             neg
);

   logic [2*OPW-1:0] a_x, b_x, prod;

   assign a_x = (2*OPW)'(a);
   assign b_x = (2*OPW)'(b);

`ifdef CALC_MUL_EN
   assign prod = a_x * b_x;
`else
   assign prod = '0;
`endif

   // subtraction reports magnitude plus a sign flag; other ops are never negative
   always_comb begin
      neg    = (op == SUB) && (a < b);
      result = (op == SUB) ? (neg ? b_x - a_x : a_x - b_x) :
               (op == MUL) ? prod : a_x + b_x;
   end

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad-driven A op B = sequencer showing the 8-bit result nibble by nibble (CALC_MUL_EN enables 0xC)
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int OPW         = 4
) (
   input logic             clk,
   input logic             rst_n,
   calc_seq_ctrl_if.slave  bus
);

   state_t           state_q, state_d;
   op_t              op_q, op_d, k_opv;
   logic [OPW-1:0]   a_q, a_d, b_q, b_d, k_val;
   logic [2*OPW-1:0] res_q, res_d, alu_res;
   logic [7:0]       cnt_q, cnt_d;
   logic [3:0]       dec_q, dec_d;
   logic             oen_q, oen_d, sel_q, sel_d, neg_q, neg_d, err_q, err_d;
   logic             alu_neg, rdy, acc, k_dig, k_op, k_eq, k_clr, k_bad;

   calc_alu #(.OPW(OPW)) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_res),
      .neg    (alu_neg)
   );

   // keys are refused only while the result is being computed or the low nibble shown
   assign rdy           = !(state_q inside {EXEC, SHOW_LO});
   assign bus.key_ready = rdy;
   assign bus.dec_in    = dec_q;
   assign bus.out_en    = oen_q;
   assign bus.nib_sel   = sel_q;
   assign bus.neg       = neg_q;
   assign bus.err       = err_q;
   assign bus.state_o   = state_q;

   // classify the incoming key; anything unrecognised is an illegal code
   always_comb begin
      acc   = bus.key_valid && rdy;
      k_val = OPW'(bus.key_code);
      k_dig = is_digit(bus.key_code);
      k_eq  = bus.key_code == KEY_EQ;
      k_clr = bus.key_code == KEY_CLR;
      k_opv = (bus.key_code == KEY_SUB) ? SUB : (bus.key_code == KEY_MUL) ? MUL : ADD;
`ifdef CALC_MUL_EN
      k_op  = bus.key_code inside {KEY_ADD, KEY_SUB, KEY_MUL};
`else
      k_op  = bus.key_code inside {KEY_ADD, KEY_SUB};
`endif
      k_bad = !(k_dig || k_op || k_eq || k_clr);
   end

   // next state, operand capture, display sequencing and error flag
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      oen_d   = 1'b0;
      sel_d   = sel_q;
      neg_d   = neg_q;
      err_d   = err_q;
      case (state_q)
         EXEC: begin
            res_d   = alu_res;
            neg_d   = alu_neg;
            dec_d   = alu_res[3:0];
            sel_d   = 1'b0;
            oen_d   = 1'b1;
            cnt_d   = 8'(HOLD_CYCLES);
            state_d = SHOW_LO;
         end
         SHOW_LO: begin
            if (cnt_q == 8'd1) begin
               dec_d   = res_q[7:4];
               sel_d   = 1'b1;
               oen_d   = 1'b1;
               state_d = SHOW_HI;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            if (acc) begin
               if (k_clr) begin
                  state_d = IDLE;
                  a_d     = '0;
                  b_d     = '0;
                  res_d   = '0;
                  neg_d   = 1'b0;
                  err_d   = 1'b0;
                  dec_d   = '0;
                  sel_d   = 1'b0;
               end else if (k_bad) begin
                  err_d = 1'b1;
               end else begin
                  case (state_q)
                     IDLE, GET_OP: begin
                        if (k_dig) begin
                           a_d     = k_val;
                           state_d = GET_OP;
                        end else if (k_op && state_q == GET_OP) begin
                           op_d    = k_opv;
                           state_d = GET_B;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     GET_B, WAIT_EQ: begin
                        if (k_dig) begin
                           b_d     = k_val;
                           state_d = WAIT_EQ;
                        end else if (k_eq && state_q == WAIT_EQ) begin
                           state_d = EXEC;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     SHOW_HI: begin
                        if (k_dig) begin
                           a_d     = k_val;
                           err_d   = 1'b0;
                           state_d = GET_OP;
                        end else if (k_op) begin
                           a_d     = OPW'(res_q[3:0]);
                           op_d    = k_opv;
                           state_d = GET_B;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         dec_q   <= '0;
         oen_q   <= 1'b0;
         sel_q   <= 1'b0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         oen_q   <= oen_d;
         sel_q   <= sel_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed key sequences checked every cycle against a behavioural calculator model
module tb_calc_seq_ctrl;
   import calc_pkg::*;

   localparam int H = 4;
`ifdef CALC_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [4:0] log_q[$];

   calc_seq_ctrl_if bus();

   calc_seq_ctrl #(.HOLD_CYCLES(H), .OPW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // behavioural model: calculator rules expressed per key class
   state_t m_st;
   op_t    m_op;
   int     m_a, m_b, m_res, m_t, m_dec;
   bit     m_neg, m_err, m_oen, m_sel;

   function automatic bit m_ready();
      return !(m_st == EXEC || m_st == SHOW_LO);
   endfunction

   task automatic m_reset();
      m_st = IDLE; m_op = ADD; m_a = 0; m_b = 0; m_res = 0; m_t = 0;
      m_dec = 0; m_neg = 0; m_err = 0; m_oen = 0; m_sel = 0;
   endtask

   task automatic m_key(input logic [3:0] k);
      bit is_op;
      is_op = k == KEY_ADD || k == KEY_SUB || (MUL_ON && k == KEY_MUL);
      if (k == KEY_CLR) begin
         m_st = IDLE; m_a = 0; m_b = 0; m_res = 0; m_neg = 0; m_err = 0; m_dec = 0; m_sel = 0;
      end else if (k <= 4'd9) begin
         if (m_st == GET_B || m_st == WAIT_EQ) begin
            m_b = int'(k); m_st = WAIT_EQ;
         end else begin
            if (m_st == SHOW_HI) m_err = 0;
            m_a = int'(k); m_st = GET_OP;
         end
      end else if (is_op && (m_st == GET_OP || m_st == SHOW_HI)) begin
         if (m_st == SHOW_HI) m_a = m_res % 16;
         m_op = (k == KEY_SUB) ? SUB : (k == KEY_MUL) ? MUL : ADD;
         m_st = GET_B;
      end else if (k == KEY_EQ && m_st == WAIT_EQ) begin
         m_st = EXEC;
      end else begin
         m_err = 1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reset();
      end else begin
         m_oen = 0;
         if (m_st == EXEC) begin
            m_neg = m_op == SUB && m_a < m_b;
            m_res = (m_op == ADD) ? m_a + m_b : (m_op == SUB) ? (m_neg ? m_b - m_a : m_a - m_b) : m_a * m_b;
            m_dec = m_res % 16; m_sel = 0; m_oen = 1; m_t = 1; m_st = SHOW_LO;
         end else if (m_st == SHOW_LO) begin
            if (m_t == H) begin
               m_dec = m_res / 16; m_sel = 1; m_oen = 1; m_st = SHOW_HI;
            end else begin
               m_t++;
            end
         end else if (bus.key_valid) begin
            m_key(bus.key_code);
         end
      end
   end

   // one cycle: compare every output with the model on the falling edge, log latch pulses
   task automatic tick();
      @(negedge clk);
      checks++;
      if (bus.state_o !== m_st || bus.dec_in !== 4'(m_dec) || bus.out_en !== m_oen ||
          bus.nib_sel !== m_sel || bus.neg !== m_neg || bus.err !== m_err || bus.key_ready !== m_ready()) begin
         errors++;
         $display("FAIL cycle t=%0t: got st=%0d dec=%h oen=%b sel=%b neg=%b err=%b rdy=%b, expected st=%0d dec=%h oen=%b sel=%b neg=%b err=%b rdy=%b",
                  $time, bus.state_o, bus.dec_in, bus.out_en, bus.nib_sel, bus.neg, bus.err, bus.key_ready,
                  m_st, 4'(m_dec), m_oen, m_sel, m_neg, m_err, m_ready());
      end
      if (bus.out_en === 1'b1) log_q.push_back({bus.nib_sel, bus.dec_in});
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      bus.key_valid = 1'b1;
      bus.key_code  = k;
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic chk_pulses(input string name, input logic [4:0] e0, input logic [4:0] e1);
      logic [4:0] p0, p1;
      chk({name, "_count"}, log_q.size(), 2);
      p0 = (log_q.size() > 0) ? log_q[0] : 5'h1f;
      p1 = (log_q.size() > 1) ? log_q[1] : 5'h1f;
      chk({name, "_lo"}, int'(p0), int'(e0));
      chk({name, "_hi"}, int'(p1), int'(e1));
   endtask

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      repeat (2) tick();
      chk("reset_state", int'(bus.state_o), int'(IDLE));
      chk("reset_ready", int'(bus.key_ready), 1);
      chk("reset_dec", int'(bus.dec_in), 0);
      rst_n = 1'b1;
      tick();

      // 3 + 5: exact latency and hold length
      press(4'd3); press(KEY_ADD); press(4'd5); press(KEY_EQ);
      chk("exec_state", int'(bus.state_o), int'(EXEC));
      chk("exec_oen", int'(bus.out_en), 0);
      tick();
      chk("lo_oen", int'(bus.out_en), 1);
      chk("lo_dec", int'(bus.dec_in), 8);
      chk("lo_sel", int'(bus.nib_sel), 0);
      repeat (H - 1) tick();
      chk("lo_last_sel", int'(bus.nib_sel), 0);
      tick();
      chk("hi_oen", int'(bus.out_en), 1);
      chk("hi_dec", int'(bus.dec_in), 0);
      chk("hi_sel", int'(bus.nib_sel), 1);
      chk("add_neg", int'(bus.neg), 0);

      // 9 + 9 = 18
      log_q.delete();
      press(4'd9); press(KEY_ADD); press(4'd9); press(KEY_EQ);
      repeat (H + 2) tick();
      chk_pulses("add18", 5'h02, 5'h11);

      // 2 - 7 with a stray op key in WAIT_EQ, then a fresh digit clears err
      log_q.delete();
      press(4'd2); press(KEY_SUB); press(4'd7); press(KEY_ADD); press(KEY_EQ);
      repeat (H + 2) tick();
      chk_pulses("sub", 5'h05, 5'h10);
      chk("sub_neg", int'(bus.neg), 1);
      chk("sub_err", int'(bus.err), 1);
      press(4'd4);
      chk("new_err", int'(bus.err), 0);
      chk("new_state", int'(bus.state_o), int'(GET_OP));

      // clear, equals in IDLE, clear again
      press(KEY_CLR);
      chk("clr_state", int'(bus.state_o), int'(IDLE));
      press(KEY_EQ);
      chk("idle_eq_err", int'(bus.err), 1);
      chk("idle_eq_state", int'(bus.state_o), int'(IDLE));
      press(KEY_CLR);
      chk("clr_err", int'(bus.err), 0);
      chk("clr_dec", int'(bus.dec_in), 0);

      // chain: 6 + 3 = 9, then - 4 = 5
      press(4'd6); press(KEY_ADD); press(4'd3); press(KEY_EQ);
      repeat (H + 2) tick();
      press(KEY_SUB);
      chk("chain_state", int'(bus.state_o), int'(GET_B));
      log_q.delete();
      press(4'd4); press(KEY_EQ);
      repeat (H + 2) tick();
      chk_pulses("chain", 5'h05, 5'h10);
      chk("chain_neg", int'(bus.neg), 0);

      // key during SHOW_LO is dropped
      press(KEY_CLR);
      log_q.delete();
      press(4'd1); press(KEY_ADD); press(4'd1); press(KEY_EQ);
      tick();
      chk("drop_ready", int'(bus.key_ready), 0);
      press(4'd7);
      repeat (H) tick();
      chk_pulses("drop", 5'h02, 5'h10);
      chk("drop_state", int'(bus.state_o), int'(SHOW_HI));

      // illegal code 0xD in GET_B
      press(KEY_CLR); press(4'd5); press(KEY_ADD); press(4'hD);
      chk("bad_err", int'(bus.err), 1);
      chk("bad_state", int'(bus.state_o), int'(GET_B));

      // multiply key
      press(KEY_CLR);
`ifdef CALC_MUL_EN
      log_q.delete();
      press(4'd9); press(KEY_MUL); press(4'd9); press(KEY_EQ);
      repeat (H + 2) tick();
      chk_pulses("mul", 5'h01, 5'h15);
`else
      press(4'd9); press(KEY_MUL);
      chk("nomul_err", int'(bus.err), 1);
      chk("nomul_state", int'(bus.state_o), int'(GET_OP));
`endif

      // asynchronous reset while showing 8 + 8 = 16 with err set
      press(KEY_CLR);
      press(4'd8); press(KEY_ADD); press(4'd8); press(4'hD); press(KEY_EQ);
      repeat (H + 2) tick();
      chk("pre_rst_dec", int'(bus.dec_in), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", int'(bus.state_o), int'(IDLE));
      chk("rst_dec", int'(bus.dec_in), 0);
      chk("rst_oen", int'(bus.out_en), 0);
      chk("rst_sel", int'(bus.nib_sel), 0);
      chk("rst_neg", int'(bus.neg), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_ready", int'(bus.key_ready), 1);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
